wt_dcache_read_ctrl: RTL and testbench

Read controller for one load port of the write-through L1 data cache; the cache instantiates one per read port (load unit, PTW). It accepts core load requests, issues tag/data reads to the cache memory arbiter, and resolves each read as hit, miss or kill. Misses go to the miss unit as cacheline refills or non-cacheable single-word reads, and the controller replays reads that lost data-path collisions.

---
 rtl/wt_dcache_read_ctrl_pkg.sv | 62 ++++++
 rtl/wt_dcache_read_ctrl_if.sv | 44 ++++
 rtl/wt_dcache_read_ctrl.sv | 171 +++++++++++++++++
 tb/tb_wt_dcache_read_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/wt_dcache_read_ctrl_pkg.sv
// wt_dcache_read_ctrl_pkg: cache geometry, core port types, platform config and FSM states
// shared by the load-port read controller and its interface.
package wt_dcache_read_ctrl_pkg;

    localparam int XLEN                = 64;
    localparam int PLEN                = 56;
    localparam int DCACHE_SET_ASSOC    = 4;
    localparam int DCACHE_INDEX_WIDTH  = 12;
    localparam int DCACHE_OFFSET_WIDTH = 4;
    localparam int DCACHE_CL_IDX_WIDTH = DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH;
    localparam int DCACHE_TAG_WIDTH    = PLEN - DCACHE_INDEX_WIDTH;
    localparam int DCACHE_USER_WIDTH   = 1;
    localparam int CACHE_ID_WIDTH      = 5;
    localparam int NR_CACHED_REGIONS   = 2;

    typedef struct packed {
        logic [NR_CACHED_REGIONS-1:0][63:0] cached_base;
        logic [NR_CACHED_REGIONS-1:0][63:0] cached_len;
    } ariane_cfg_t;

    // Region 1 has zero length and therefore never matches.
    localparam ariane_cfg_t ArianeDefaultConfig = '{
        cached_base: {64'h0, 64'h8000_0000},
        cached_len:  {64'h0, 64'h4000_0000}
    };

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic                          data_req;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic                         data_gnt;
        logic                         data_rvalid;
        logic [XLEN-1:0]              data_rdata;
        logic [DCACHE_USER_WIDTH-1:0] data_ruser;
    } dcache_req_o_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MISS_REQ,
        MISS_WAIT,
        KILL_MISS,
        KILL_MISS_ACK,
        REPLAY_REQ,
        REPLAY_READ
    } rd_state_e;

    function automatic logic is_inside_cacheable_regions(ariane_cfg_t cfg, logic [63:0] addr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NR_CACHED_REGIONS; i++)
            hit |= (addr >= cfg.cached_base[i]) && ((addr - cfg.cached_base[i]) < cfg.cached_len[i]);
        return hit;
    endfunction

endpackage

// File: rtl/wt_dcache_read_ctrl_if.sv
// wt_dcache_read_ctrl_if: miss-unit and cache-memory signals of one read port;
// master is the read controller, slave is the miss unit / memory arbiter side.
interface wt_dcache_read_ctrl_if;
    import wt_dcache_read_ctrl_pkg::*;

    logic                           miss_req;
    logic                           miss_ack;
    logic                           miss_we;
    logic [XLEN-1:0]                miss_wdata;
    logic [DCACHE_USER_WIDTH-1:0]   miss_wuser;
    logic [DCACHE_SET_ASSOC-1:0]    miss_vld_bits;
    logic [PLEN-1:0]                miss_paddr;
    logic                           miss_nc;
    logic [2:0]                     miss_size;
    logic [CACHE_ID_WIDTH-1:0]      miss_id;
    logic                           miss_replay;
    logic                           miss_rtrn_vld;
    logic                           wr_cl_vld;
    logic [DCACHE_TAG_WIDTH-1:0]    rd_tag;
    logic [DCACHE_CL_IDX_WIDTH-1:0] rd_idx;
    logic [DCACHE_OFFSET_WIDTH-1:0] rd_off;
    logic                           rd_req;
    logic                           rd_tag_only;
    logic                           rd_ack;
    logic [XLEN-1:0]                rd_data;
    logic [DCACHE_USER_WIDTH-1:0]   rd_user;
    logic [DCACHE_SET_ASSOC-1:0]    rd_vld_bits;
    logic [DCACHE_SET_ASSOC-1:0]    rd_hit_oh;

    modport master (
        output miss_req, miss_we, miss_wdata, miss_wuser, miss_vld_bits, miss_paddr,
               miss_nc, miss_size, miss_id, rd_tag, rd_idx, rd_off, rd_req, rd_tag_only,
        input  miss_ack, miss_replay, miss_rtrn_vld, wr_cl_vld, rd_ack, rd_data,
               rd_user, rd_vld_bits, rd_hit_oh
    );

    modport slave (
        input  miss_req, miss_we, miss_wdata, miss_wuser, miss_vld_bits, miss_paddr,
               miss_nc, miss_size, miss_id, rd_tag, rd_idx, rd_off, rd_req, rd_tag_only,
        output miss_ack, miss_replay, miss_rtrn_vld, wr_cl_vld, rd_ack, rd_data,
               rd_user, rd_vld_bits, rd_hit_oh
    );

endinterface

// File: rtl/wt_dcache_read_ctrl.sv
// wt_dcache_read_ctrl: load-port read controller of the write-through L1 dcache (hit/miss/kill/replay).
// Define WT_DCACHE_CTRL_ASSERT_EN to compile in simulation assertions.
module wt_dcache_read_ctrl
    import wt_dcache_read_ctrl_pkg::*;
#(
    parameter logic [CACHE_ID_WIDTH-1:0] RdTxId    = 1,
    parameter ariane_cfg_t               ArianeCfg = ArianeDefaultConfig
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cache_en_i,
    output logic                  busy_o,
    input  logic                  stall_i,
    input  dcache_req_i_t         req_port_i,
    output dcache_req_o_t         req_port_o,
    wt_dcache_read_ctrl_if.master bus,
    input  logic [XLEN-1:0]       patid_i
);

    rd_state_e                      r_state, w_state_d;
    logic [DCACHE_CL_IDX_WIDTH-1:0] r_idx;
    logic [DCACHE_OFFSET_WIDTH-1:0] r_off;
    logic [DCACHE_TAG_WIDTH-1:0]    r_tag;
    logic [1:0]                     r_size;
    logic [DCACHE_SET_ASSOC-1:0]    r_vld_bits;
    logic                           r_rd_ack;
    logic                           w_addr_sel, w_save_tag, w_vld_we;
    logic                           w_gnt, w_rvalid, w_rd_req, w_miss_req, w_nc;
    logic                           w_new_req, w_kill;
    logic [PLEN-1:0]                w_paddr;
    logic                           w_unused_patid;

    assign w_new_req = req_port_i.data_req && !stall_i;
    assign w_kill    = req_port_i.kill_req;

    always_comb begin
        w_state_d  = r_state;
        w_addr_sel = 1'b0;
        w_save_tag = 1'b0;
        w_vld_we   = 1'b0;
        w_gnt      = 1'b0;
        w_rvalid   = 1'b0;
        w_rd_req   = 1'b0;
        w_miss_req = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_addr_sel = 1'b1;
                w_rd_req   = w_new_req;
                if (w_new_req && bus.rd_ack) begin
                    w_gnt     = 1'b1;
                    w_state_d = READ;
                end
            end
            READ, REPLAY_READ: begin
                w_rd_req = 1'b1;
                if (w_kill) begin
                    w_rvalid  = 1'b1;
                    w_state_d = IDLE;
                end else if (req_port_i.tag_valid || r_state == REPLAY_READ) begin
                    w_save_tag = (r_state == READ);
                    if (bus.wr_cl_vld || !r_rd_ack) begin
                        w_state_d = REPLAY_REQ;
                    end else if (|bus.rd_hit_oh && cache_en_i) begin
                        // A hit frees the port this cycle, so a new request may be granted right away.
                        w_rvalid   = 1'b1;
                        w_state_d  = IDLE;
                        w_addr_sel = w_new_req;
                        if (w_new_req && bus.rd_ack) begin
                            w_gnt     = 1'b1;
                            w_state_d = READ;
                        end
                    end else begin
                        w_vld_we  = 1'b1;
                        w_state_d = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                w_miss_req = 1'b1;
                if (w_kill) begin
                    w_rvalid  = 1'b1;
                    w_state_d = bus.miss_ack ? KILL_MISS : KILL_MISS_ACK;
                end else if (bus.miss_replay) begin
                    w_state_d = REPLAY_REQ;
                end else if (bus.miss_ack) begin
                    w_state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (w_kill || bus.miss_rtrn_vld) begin
                    w_rvalid  = 1'b1;
                    w_state_d = (w_kill && !bus.miss_rtrn_vld) ? KILL_MISS : IDLE;
                end
            end
            REPLAY_REQ: begin
                w_rd_req = 1'b1;
                if (w_kill) begin
                    w_rvalid  = 1'b1;
                    w_state_d = IDLE;
                end else if (bus.rd_ack) begin
                    w_state_d = REPLAY_READ;
                end
            end
            KILL_MISS_ACK: begin
                w_miss_req = 1'b1;
                w_state_d  = bus.miss_replay ? IDLE : bus.miss_ack ? KILL_MISS : KILL_MISS_ACK;
            end
            KILL_MISS: w_state_d = bus.miss_rtrn_vld ? IDLE : KILL_MISS;
            default:   w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_off      <= '0;
            r_tag      <= '0;
            r_size     <= '0;
            r_vld_bits <= '0;
            r_rd_ack   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_rd_ack <= bus.rd_ack;
            if (w_gnt) begin
                r_idx  <= req_port_i.address_index[DCACHE_INDEX_WIDTH-1:DCACHE_OFFSET_WIDTH];
                r_off  <= req_port_i.address_index[DCACHE_OFFSET_WIDTH-1:0];
                r_size <= req_port_i.data_size;
            end
            if (w_save_tag) r_tag <= req_port_i.address_tag;
            if (w_vld_we) r_vld_bits <= bus.rd_vld_bits;
        end
    end

    assign w_paddr = {r_tag, r_idx, r_off};
    assign w_nc    = !cache_en_i || !is_inside_cacheable_regions(ArianeCfg, 64'(w_paddr));

    assign busy_o     = (r_state != IDLE);
    assign req_port_o = '{
        data_gnt:    w_gnt,
        data_rvalid: w_rvalid,
        data_rdata:  bus.rd_data,
        data_ruser:  bus.rd_user
    };

    assign bus.rd_req      = w_rd_req;
    assign bus.rd_tag_only = 1'b0;
    assign bus.rd_tag      = (r_state == READ) ? req_port_i.address_tag : r_tag;
    assign bus.rd_idx      = w_addr_sel ? req_port_i.address_index[DCACHE_INDEX_WIDTH-1:DCACHE_OFFSET_WIDTH] : r_idx;
    assign bus.rd_off      = w_addr_sel ? req_port_i.address_index[DCACHE_OFFSET_WIDTH-1:0] : r_off;

    assign bus.miss_req      = w_miss_req;
    assign bus.miss_we       = 1'b0;
    assign bus.miss_wdata    = '0;
    assign bus.miss_wuser    = '0;
    assign bus.miss_vld_bits = r_vld_bits;
    assign bus.miss_paddr    = w_paddr;
    assign bus.miss_nc       = w_nc;
    assign bus.miss_size     = w_nc ? {1'b0, r_size} : 3'b111;
    assign bus.miss_id       = RdTxId;

    assign w_unused_patid = ^patid_i;

`ifdef WT_DCACHE_CTRL_ASSERT_EN
    a_hit_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(bus.rd_hit_oh));
    a_gnt_state:  assert property (@(posedge clk_i) disable iff (!rst_ni) w_gnt |-> (r_state inside {IDLE, READ}));
    a_miss_idle:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_miss_req && r_state == IDLE));
`else
`endif

endmodule

// File: tb/tb_wt_dcache_read_ctrl.sv
// tb_wt_dcache_read_ctrl: directed stimulus with a scoreboard of expected gnt/rvalid/miss events.
module tb_wt_dcache_read_ctrl;
    import wt_dcache_read_ctrl_pkg::*;

    localparam logic [CACHE_ID_WIDTH-1:0] TX_ID = 5'd1;
    localparam int EV_GNT = 0, EV_RVALID = 1, EV_MISS = 2;

    logic            clk = 1'b0, rst_n = 1'b0, cache_en = 1'b1, stall = 1'b0, busy;
    logic [XLEN-1:0] patid = '0;
    dcache_req_i_t   req;
    dcache_req_o_t   rsp;

    wt_dcache_read_ctrl_if bus();

    wt_dcache_read_ctrl #(.RdTxId(TX_ID)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cache_en_i(cache_en), .busy_o(busy), .stall_i(stall),
        .req_port_i(req), .req_port_o(rsp), .bus(bus), .patid_i(patid)
    );

    always #5 clk = ~clk;

    typedef struct { int kind; logic [63:0] a; logic [63:0] b; } exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0;

    function automatic logic [63:0] miss_info(logic nc, logic [2:0] size, logic [CACHE_ID_WIDTH-1:0] id);
        return 64'({nc, size, id});
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(int kind, logic [63:0] a, logic [63:0] b);
        sb.push_back('{kind, a, b});
    endtask

    task automatic observe(int kind, logic [63:0] a, logic [63:0] b);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event at %0t: got kind=%0d a=%h b=%h expected none", $time, kind, a, b);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.a !== a || e.b !== b) begin
                failures++;
                $display("FAIL event at %0t: got kind=%0d a=%h b=%h expected kind=%0d a=%h b=%h",
                         $time, kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp.data_rvalid) observe(EV_RVALID, rsp.data_rdata, 64'h0);
            if (rsp.data_gnt) observe(EV_GNT, 64'h0, 64'h0);
            if (bus.miss_req && bus.miss_ack)
                observe(EV_MISS, 64'(bus.miss_paddr), miss_info(bus.miss_nc, bus.miss_size, bus.miss_id));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req.data_req      = 1'b0;
        req.tag_valid     = 1'b0;
        req.kill_req      = 1'b0;
        bus.rd_ack        = 1'b0;
        bus.rd_hit_oh     = '0;
        bus.miss_ack      = 1'b0;
        bus.miss_rtrn_vld = 1'b0;
        bus.wr_cl_vld     = 1'b0;
    endtask

    task automatic issue(logic [11:0] idx, logic [1:0] size);
        req.data_req      = 1'b1;
        req.address_index = idx;
        req.data_size     = size;
        bus.rd_ack        = 1'b1;
        expect_ev(EV_GNT, 64'h0, 64'h0);
    endtask

    task automatic tag_phase(logic [DCACHE_TAG_WIDTH-1:0] tag, logic [3:0] hit, logic [63:0] data);
        req.data_req    = 1'b0;
        req.tag_valid   = 1'b1;
        req.address_tag = tag;
        bus.rd_hit_oh   = hit;
        bus.rd_data     = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0;
        idle();
        bus.rd_data     = '0;
        bus.rd_user     = '0;
        bus.rd_vld_bits = '0;
        bus.miss_replay = 1'b0;
        #12;
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_gnt", 64'(rsp.data_gnt), 64'h0);
        check("reset_rvalid", 64'(rsp.data_rvalid), 64'h0);
        check("reset_miss_req", 64'(bus.miss_req), 64'h0);
        check("reset_rd_req", 64'(bus.rd_req), 64'h0);
        check("reset_miss_id", 64'(bus.miss_id), 64'(TX_ID));
        check("reset_miss_paddr", 64'(bus.miss_paddr), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        // stall blocks acceptance
        req.data_req = 1'b1; req.address_index = 12'h040; stall = 1'b1; bus.rd_ack = 1'b1;
        #1 check("stall_rd_req", 64'(bus.rd_req), 64'h0);
        step(); stall = 1'b0; idle();
        // hit
        issue(12'h040, 2'b11);
        #1 check("hit_rd_req", 64'(bus.rd_req), 64'h1);
        check("hit_rd_idx", 64'(bus.rd_idx), 64'h04);
        step();
        tag_phase(44'h80000, 4'b0010, 64'hDEAD_BEEF); expect_ev(EV_RVALID, 64'hDEAD_BEEF, 64'h0);
        step(); idle();
        #1 check("hit_busy_after", 64'(busy), 64'h0);
        // cacheable miss
        issue(12'h040, 2'b11); step();
        tag_phase(44'h80000, 4'b0000, 64'h0); bus.rd_vld_bits = 4'b1011; step();
        idle(); bus.miss_ack = 1'b1;
        expect_ev(EV_MISS, 64'h8000_0040, miss_info(1'b0, 3'b111, TX_ID));
        #1 check("miss_vld_bits", 64'(bus.miss_vld_bits), 64'hB);
        step(); bus.miss_ack = 1'b0;
        repeat (4) step();
        check("miss_wait_busy", 64'(busy), 64'h1);
        bus.miss_rtrn_vld = 1'b1; bus.rd_data = 64'h1234_5678_9ABC_DEF0;
        expect_ev(EV_RVALID, 64'h1234_5678_9ABC_DEF0, 64'h0);
        step(); idle();
        #1 check("miss_busy_after", 64'(busy), 64'h0);
        // cache disabled forces non-cacheable
        cache_en = 1'b0;
        issue(12'h040, 2'b11); step();
        tag_phase(44'h80000, 4'b0001, 64'h0); step();
        idle(); bus.miss_ack = 1'b1;
        expect_ev(EV_MISS, 64'h8000_0040, miss_info(1'b1, 3'b011, TX_ID));
        step(); bus.miss_ack = 1'b0; bus.miss_rtrn_vld = 1'b1; bus.rd_data = 64'h0123_4567_89AB_CDEF;
        expect_ev(EV_RVALID, 64'h0123_4567_89AB_CDEF, 64'h0);
        step(); idle(); cache_en = 1'b1;
        // collision replay; miss_ack held high so a stray miss would show up
        issue(12'h040, 2'b11); bus.miss_ack = 1'b1; step();
        tag_phase(44'h80000, 4'b0010, 64'h0); bus.wr_cl_vld = 1'b1; step();
        req.tag_valid = 1'b0; req.address_tag = '0; bus.wr_cl_vld = 1'b0; bus.rd_hit_oh = '0;
        #1 check("replay_rd_tag", 64'(bus.rd_tag), 64'h80000);
        check("replay_rd_idx", 64'(bus.rd_idx), 64'h04);
        check("replay_rd_req", 64'(bus.rd_req), 64'h1);
        step();
        bus.rd_hit_oh = 4'b0010; bus.rd_data = 64'hCAFE; expect_ev(EV_RVALID, 64'hCAFE, 64'h0);
        step(); idle();
        #1 check("replay_busy_after", 64'(busy), 64'h0);
        // kill during MISS_WAIT
        issue(12'h080, 2'b01); step();
        tag_phase(44'h80000, 4'b0000, 64'h0); step();
        idle(); bus.miss_ack = 1'b1;
        expect_ev(EV_MISS, 64'h8000_0080, miss_info(1'b0, 3'b111, TX_ID));
        step(); bus.miss_ack = 1'b0; req.kill_req = 1'b1; bus.rd_data = 64'h5A5A;
        expect_ev(EV_RVALID, 64'h5A5A, 64'h0);
        step(); req.kill_req = 1'b0;
        #1 check("kill_busy_wait", 64'(busy), 64'h1);
        repeat (2) step();
        bus.miss_rtrn_vld = 1'b1; bus.rd_data = 64'hBAD;
        step(); bus.miss_rtrn_vld = 1'b0;
        #1 check("kill_busy_after", 64'(busy), 64'h0);
        // back-to-back hits
        issue(12'h080, 2'b11); step();
        tag_phase(44'h80000, 4'b0100, 64'h1111); expect_ev(EV_RVALID, 64'h1111, 64'h0);
        issue(12'h0C0, 2'b11);
        #1 check("b2b_rd_idx", 64'(bus.rd_idx), 64'h0C);
        step();
        tag_phase(44'h80000, 4'b1000, 64'h2222); expect_ev(EV_RVALID, 64'h2222, 64'h0);
        step(); idle();
        #1 check("b2b_busy_after", 64'(busy), 64'h0);
        repeat (3) step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending events expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
